mem_wb_stage_hs: RTL and testbench

MEM_WB_STAGE_HS -- requirements
Module: mem_wb_stage_hs

---
 rtl/mem_wb_stage_hs.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_wb_stage_hs.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_stage_hs                                                      |
// | MEM/WB pipeline stage: data-memory handshake with per-access         |
// | timeout, load alignment/extension and registered writeback.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_wb_stage_hs #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_type,
  input  logic [31:0]       ex_ir,
  input  logic [XLEN-1:0]   ex_aluout,
  input  logic [XLEN-1:0]   ex_rs2,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [2:0]        wb_type,
  output logic [31:0]       wb_ir,
  output logic [XLEN-1:0]   wb_result,
  output logic              wb_we,
  output logic [1:0]        wb_exc
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [2:0] c_TY_LOAD = 3'b000;
  localparam logic [2:0] c_TY_ILOG = 3'b001;
  localparam logic [2:0] c_TY_S    = 3'b010;
  localparam logic [2:0] c_TY_R    = 3'b011;
  localparam logic [2:0] c_TY_U    = 3'b101;
  localparam logic [2:0] c_TY_J    = 3'b110;

  localparam logic [1:0] c_EXC_NONE  = 2'b00;
  localparam logic [1:0] c_EXC_MISAL = 2'b01;
  localparam logic [1:0] c_EXC_ILL   = 2'b10;
  localparam logic [1:0] c_EXC_TMO   = 2'b11;

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_memop;
  logic [2:0]      w_f3;
  logic [1:0]      w_size;
  logic            w_legal;
  logic            w_misal;
  logic            w_go;
  logic [OFFW-1:0] w_off;
  logic [NB-1:0]   w_mask;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_ldata;
  logic            w_req;
  logic            w_tmo;
  logic            w_stall;
  logic [1:0]      w_exc;
  logic [XLEN-1:0] w_res;
  logic            w_we;

  // Decode the slot: memop class, funct3 legality and natural alignment.
  always_comb begin
    w_is_load  = (ex_type == c_TY_LOAD);
    w_is_store = (ex_type == c_TY_S);
    w_memop    = ex_valid && (w_is_load || w_is_store);
    w_f3       = ex_ir[14:12];
    w_size     = w_f3[1:0];
    w_off      = ex_aluout[OFFW-1:0];
    w_legal    = 1'b0;
    if (w_is_load) begin
      case (w_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (w_f3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end
    // Bit 2 always exists since XLEN >= 32; doubleword only reachable at 64.
    case (w_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = ex_aluout[0];
      2'd2:    w_misal = |ex_aluout[1:0];
      default: w_misal = |ex_aluout[2:0];
    endcase
    w_go = w_memop && w_legal && !w_misal;
  end

  // Memory-side request fields: aligned address, lane enables, replicated data.
  always_comb begin
    case (w_size)
      2'd0:    w_mask = NB'(1);
      2'd1:    w_mask = NB'(3);
      2'd2:    w_mask = NB'(15);
      default: w_mask = '1;
    endcase
    case (w_size)
      2'd0:    dmem_wdata = {NB{ex_rs2[7:0]}};
      2'd1:    dmem_wdata = {(NB/2){ex_rs2[15:0]}};
      2'd2:    dmem_wdata = {(NB/4){ex_rs2[31:0]}};
      default: dmem_wdata = ex_rs2;
    endcase
    dmem_addr = {ex_aluout[XLEN-1:OFFW], {OFFW{1'b0}}};
    dmem_be   = w_mask << w_off;
    dmem_we   = ex_valid && w_is_store;
  end

  // Extract the addressed bytes from the read word and extend to XLEN.
  always_comb begin
    w_shift = dmem_rdata >> {w_off, 3'b000};
    case (w_f3)
      3'b000:  w_ldata = XLEN'($signed(w_shift[7:0]));
      3'b001:  w_ldata = XLEN'($signed(w_shift[15:0]));
      3'b010:  w_ldata = XLEN'($signed(w_shift[31:0]));
      3'b100:  w_ldata = XLEN'(w_shift[7:0]);
      3'b101:  w_ldata = XLEN'(w_shift[15:0]);
      3'b110:  w_ldata = XLEN'(w_shift[31:0]);
      default: w_ldata = w_shift;
    endcase
  end

  // Handshake FSM next state and request/stall generation. The timeout cycle
  // itself is a completion (stall low) so the aborted slot retires with 11
  // instead of being re-issued from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = w_go;
        if (w_go && !dmem_ack) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_req = 1'b1;
        w_tmo = (r_cnt == c_TMO_LAST) && !dmem_ack;
        if (dmem_ack || w_tmo) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    dmem_req = w_req && !rst;
    w_stall  = w_req && !dmem_ack && !w_tmo && !rst;
    stall    = w_stall;
  end

  // FSM state and WAIT-cycle counter; counter restarts on every WAIT entry.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  // Writeback value, write enable and exception code for the current slot.
  always_comb begin
    w_exc = c_EXC_NONE;
    if (w_memop) begin
      if (!w_legal)      w_exc = c_EXC_ILL;
      else if (w_misal)  w_exc = c_EXC_MISAL;
      else if (w_tmo)    w_exc = c_EXC_TMO;
    end
    w_res = ex_aluout;
    w_we  = 1'b0;
    case (ex_type)
      c_TY_R, c_TY_ILOG, c_TY_U, c_TY_J: w_we = ex_valid && (|ex_ir[11:7]);
      c_TY_LOAD: begin
        if (w_memop && w_exc == c_EXC_NONE) begin
          w_res = w_ldata;
          w_we  = |ex_ir[11:7];
        end
      end
      default: w_we = 1'b0;
    endcase
  end

  // WB pipeline register; a stalled edge retires a bubble.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_type   <= 3'b000;
      wb_ir     <= 32'd0;
      wb_result <= '0;
      wb_we     <= 1'b0;
      wb_exc    <= c_EXC_NONE;
    end else if (w_stall) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
    end else begin
      wb_valid  <= ex_valid;
      wb_type   <= ex_type;
      wb_ir     <= ex_ir;
      wb_result <= w_res;
      wb_we     <= w_we;
      wb_exc    <= w_exc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_wb_stage_hs                                                   |
// | Scoreboard bench for mem_wb_stage_hs (XLEN=32, TIMEOUT=4).           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_wb_stage_hs;

  localparam int XLEN = 32;
  localparam int NB   = XLEN / 8;

  localparam logic [2:0] TY_LD = 3'b000;
  localparam logic [2:0] TY_IL = 3'b001;
  localparam logic [2:0] TY_S  = 3'b010;
  localparam logic [2:0] TY_R  = 3'b011;
  localparam logic [2:0] TY_U  = 3'b101;
  localparam logic [2:0] TY_J  = 3'b110;
  localparam logic [2:0] TY_B  = 3'b111;

  logic            clk2 = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [2:0]      ex_type;
  logic [31:0]     ex_ir;
  logic [XLEN-1:0] ex_aluout;
  logic [XLEN-1:0] ex_rs2;
  logic            stall;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [NB-1:0]   dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_valid;
  logic [2:0]      wb_type;
  logic [31:0]     wb_ir;
  logic [XLEN-1:0] wb_result;
  logic            wb_we;
  logic [1:0]      wb_exc;

  typedef struct packed {
    logic [31:0]     ir;
    logic [2:0]      ty;
    logic [XLEN-1:0] res;
    logic            we;
    logic [1:0]      exc;
  } wb_t;

  wb_t sbq[$];
  wb_t exp_w;
  wb_t obs_w;
  int  vec = 0;
  int  err = 0;

  int              n_req;
  int              n_stall;
  int              n_bub;
  logic            done;
  logic [XLEN-1:0] c_addr;
  logic [XLEN-1:0] c_wdata;
  logic [NB-1:0]   c_be;
  logic            c_we;

  mem_wb_stage_hs #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk2(clk2), .rst(rst), .ex_valid(ex_valid), .ex_type(ex_type), .ex_ir(ex_ir),
    .ex_aluout(ex_aluout), .ex_rs2(ex_rs2), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_type(wb_type),
    .wb_ir(wb_ir), .wb_result(wb_result), .wb_we(wb_we), .wb_exc(wb_exc)
  );

  always #5 clk2 = ~clk2;

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, 7'h03};
  endfunction

  task automatic push_exp(input logic [2:0] ty, input logic [31:0] ir,
                          input logic [XLEN-1:0] res, input logic we, input logic [1:0] exc);
    wb_t e;
    e.ir = ir; e.ty = ty; e.res = res; e.we = we; e.exc = exc;
    sbq.push_back(e);
  endtask

  // Present one slot at a negedge and run the memory side: ack_at is the cycle
  // index (0 = issue cycle) on which ack is returned, -1 for never. Returns
  // just after the edge on which the slot retires.
  task automatic run_slot(input logic [2:0] ty, input logic [31:0] ir, input logic [XLEN-1:0] alu,
                          input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] rdata, input int ack_at);
    @(negedge clk2);
    ex_valid = 1'b1; ex_type = ty; ex_ir = ir; ex_aluout = alu; ex_rs2 = rs2; dmem_rdata = rdata;
    n_req = 0; n_stall = 0; n_bub = 0; done = 1'b0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk2);
      dmem_ack = (c == ack_at);
      #1;
      if (dmem_req === 1'b1) begin
        if (n_req == 0) begin
          c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
        end
        n_req++;
      end
      if (stall === 1'b1) n_stall++;
      else done = 1'b1;
      @(posedge clk2); #1;
      if (!done && wb_valid !== 1'b0) n_bub++;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b1; ex_type = TY_LD; ex_ir = mk_ir(3'b010, 5'd5);
    ex_aluout = 32'h1000; ex_rs2 = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk2);
    #1;
    vec++;
    if ({wb_valid, wb_we, wb_exc, wb_type, wb_ir, wb_result} !== '0) begin
      err++; $display("FAIL reset_wb: got v=%b we=%b exc=%b ty=%b ir=%h res=%h, exp all zero",
                      wb_valid, wb_we, wb_exc, wb_type, wb_ir, wb_result);
    end
    vec++;
    if ({dmem_req, stall} !== 2'b00) begin
      err++; $display("FAIL reset_req: got req=%b stall=%b, exp 0 0", dmem_req, stall);
    end
    @(negedge clk2);
    rst = 1'b0; ex_valid = 1'b0;
    @(posedge clk2); #1;
    vec++;
    if (wb_valid !== 1'b0) begin
      err++; $display("FAIL idle_valid: got %b exp 0", wb_valid);
    end
  endtask

  task automatic test_lw_fast();
    push_exp(TY_LD, mk_ir(3'b010, 5'd5), 32'hDEADBEEF, 1'b1, 2'b00);
    run_slot(TY_LD, mk_ir(3'b010, 5'd5), 32'h1000, '0, 32'hDEADBEEF, 0);
    vec++;
    if (n_stall !== 0 || n_req !== 1 || {c_addr, c_be, c_we} !== {32'h1000, 4'b1111, 1'b0}) begin
      err++; $display("FAIL lw_req: got stall=%0d req=%0d addr=%h be=%b we=%b, exp 0 1 1000 1111 0",
                      n_stall, n_req, c_addr, c_be, c_we);
    end
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL lw_wb: got v=%b %h, exp %h", wb_valid, obs_w, exp_w);
    end
  endtask

  task automatic test_lb_wait();
    push_exp(TY_LD, mk_ir(3'b000, 5'd6), 32'hFFFFFF80, 1'b1, 2'b00);
    run_slot(TY_LD, mk_ir(3'b000, 5'd6), 32'h1003, '0, 32'h80112233, 3);
    vec++;
    if (n_stall !== 3 || n_bub !== 0 || {c_addr, c_be} !== {32'h1000, 4'b1000}) begin
      err++; $display("FAIL lb_req: got stall=%0d bub=%0d addr=%h be=%b, exp 3 0 1000 1000",
                      n_stall, n_bub, c_addr, c_be);
    end
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL lb_wb: got v=%b %h, exp %h", wb_valid, obs_w, exp_w);
    end
  endtask

  task automatic test_stores();
    logic [XLEN-1:0] addr [0:2];
    logic [XLEN-1:0] data [0:2];
    logic [2:0]      f3   [0:2];
    logic [NB-1:0]   ebe  [0:2];
    logic [XLEN-1:0] ewd  [0:2];
    int              ack  [0:2];
    addr = '{32'h2002, 32'h3001, 32'h3000};
    data = '{32'h0000ABCD, 32'h123456AA, 32'h12345678};
    f3   = '{3'b001, 3'b000, 3'b010};
    ebe  = '{4'b1100, 4'b0010, 4'b1111};
    ewd  = '{32'hABCDABCD, 32'hAAAAAAAA, 32'h12345678};
    ack  = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      push_exp(TY_S, mk_ir(f3[i], 5'd7), addr[i], 1'b0, 2'b00);
      run_slot(TY_S, mk_ir(f3[i], 5'd7), addr[i], data[i], '0, ack[i]);
      vec++;
      if ({c_be, c_wdata, c_we} !== {ebe[i], ewd[i], 1'b1} || n_stall !== ack[i]) begin
        err++; $display("FAIL store_req[%0d]: got be=%b wd=%h we=%b stall=%0d, exp %b %h 1 %0d",
                        i, c_be, c_wdata, c_we, n_stall, ebe[i], ewd[i], ack[i]);
      end
      exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
      if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
        err++; $display("FAIL store_wb[%0d]: got v=%b %h, exp %h", i, wb_valid, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]      f3  [0:3];
    logic [4:0]      rd  [0:3];
    logic [XLEN-1:0] adr [0:3];
    logic [XLEN-1:0] rdt [0:3];
    logic [XLEN-1:0] res [0:3];
    logic            we  [0:3];
    f3  = '{3'b001, 3'b101, 3'b100, 3'b001};
    rd  = '{5'd1, 5'd2, 5'd3, 5'd0};
    adr = '{32'h1002, 32'h1002, 32'h1001, 32'h1000};
    rdt = '{32'h89AB0000, 32'h89AB0000, 32'h0000F000, 32'h00008001};
    res = '{32'hFFFF89AB, 32'h000089AB, 32'h000000F0, 32'hFFFF8001};
    we  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push_exp(TY_LD, mk_ir(f3[i], rd[i]), res[i], we[i], 2'b00);
      run_slot(TY_LD, mk_ir(f3[i], rd[i]), adr[i], '0, rdt[i], i);
      exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
      if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
        err++; $display("FAIL ldext_wb[%0d]: got v=%b %h, exp %h", i, wb_valid, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_faults();
    logic [2:0]      ty  [0:5];
    logic [2:0]      f3  [0:5];
    logic [XLEN-1:0] adr [0:5];
    logic [1:0]      exc [0:5];
    ty  = '{TY_LD, TY_LD, TY_S, TY_LD, TY_S, TY_LD};
    f3  = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100, 3'b110};
    adr = '{32'h1002, 32'h1001, 32'h2003, 32'h1001, 32'h2000, 32'h1000};
    exc = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      push_exp(ty[i], mk_ir(f3[i], 5'd5), adr[i], 1'b0, exc[i]);
      run_slot(ty[i], mk_ir(f3[i], 5'd5), adr[i], 32'h55, 32'hCAFEF00D, 0);
      vec++;
      if (n_req !== 0 || n_stall !== 0) begin
        err++; $display("FAIL fault_req[%0d]: got req=%0d stall=%0d, exp 0 0", i, n_req, n_stall);
      end
      exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
      if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
        err++; $display("FAIL fault_wb[%0d]: got v=%b %h, exp %h", i, wb_valid, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_timeout();
    push_exp(TY_LD, mk_ir(3'b010, 5'd9), 32'h4000, 1'b0, 2'b11);
    run_slot(TY_LD, mk_ir(3'b010, 5'd9), 32'h4000, '0, 32'h11111111, -1);
    vec++;
    if (n_req !== 5 || n_stall !== 4 || n_bub !== 0) begin
      err++; $display("FAIL tmo_cnt: got req=%0d stall=%0d bub=%0d, exp 5 4 0", n_req, n_stall, n_bub);
    end
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL tmo_wb: got v=%b %h, exp %h", wb_valid, obs_w, exp_w);
    end
    push_exp(TY_LD, mk_ir(3'b010, 5'd10), 32'h0BADF00D, 1'b1, 2'b00);
    run_slot(TY_LD, mk_ir(3'b010, 5'd10), 32'h1004, '0, 32'h0BADF00D, 0);
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || n_stall !== 0 || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL tmo_next: got v=%b stall=%0d %h, exp %h", wb_valid, n_stall, obs_w, exp_w);
    end
    // ack on the very cycle the counter reaches TIMEOUT-1 completes normally
    push_exp(TY_LD, mk_ir(3'b010, 5'd11), 32'h13579BDF, 1'b1, 2'b00);
    run_slot(TY_LD, mk_ir(3'b010, 5'd11), 32'h1008, '0, 32'h13579BDF, 4);
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || n_stall !== 4 || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL ack_edge: got v=%b stall=%0d %h, exp stall 4 %h", wb_valid, n_stall, obs_w, exp_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]      ty  [0:7];
    logic [4:0]      rd  [0:7];
    logic [XLEN-1:0] alu [0:7];
    logic [XLEN-1:0] res [0:7];
    logic            we  [0:7];
    ty  = '{TY_R, TY_R, TY_B, TY_U, TY_J, TY_IL, TY_LD, TY_R};
    rd  = '{5'd3, 5'd0, 5'd4, 5'd1, 5'd1, 5'd2, 5'd8, 5'd31};
    alu = '{32'h55, 32'h66, 32'h200, 32'hABCDE000, 32'h104, 32'hFF, 32'h100C, 32'h7};
    res = '{32'h55, 32'h66, 32'h200, 32'hABCDE000, 32'h104, 32'hFF, 32'h76543210, 32'h7};
    we  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      push_exp(ty[i], mk_ir(3'b010, rd[i]), res[i], we[i], 2'b00);
      // ack pulses during non-memory slots must be ignored
      run_slot(ty[i], mk_ir(3'b010, rd[i]), alu[i], '0, 32'h76543210, (ty[i] == TY_LD) ? 2 : 0);
      vec++;
      if (ty[i] != TY_LD && (n_req !== 0 || n_stall !== 0)) begin
        err++; $display("FAIL b2b_req[%0d]: got req=%0d stall=%0d, exp 0 0", i, n_req, n_stall);
      end
      exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
      if (!done || wb_valid !== 1'b1 || obs_w !== exp_w) begin
        err++; $display("FAIL b2b_wb[%0d]: got v=%b %h, exp %h", i, wb_valid, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_rst_wait();
    @(negedge clk2);
    ex_valid = 1'b1; ex_type = TY_LD; ex_ir = mk_ir(3'b010, 5'd5); ex_aluout = 32'h5000;
    dmem_ack = 1'b0;
    @(negedge clk2);
    @(negedge clk2);
    #1;
    vec++;
    if ({dmem_req, stall} !== 2'b11) begin
      err++; $display("FAIL rst_pre: got req=%b stall=%b, exp 1 1", dmem_req, stall);
    end
    #1 rst = 1'b1;
    #1;
    vec++;
    if ({dmem_req, stall, wb_valid} !== 3'b000) begin
      err++; $display("FAIL rst_drop: got req=%b stall=%b v=%b, exp 0 0 0", dmem_req, stall, wb_valid);
    end
    ex_valid = 1'b0;
    @(posedge clk2); #1;
    @(negedge clk2);
    rst = 1'b0;
    push_exp(TY_R, mk_ir(3'b000, 5'd0), 32'h77, 1'b0, 2'b00);
    run_slot(TY_R, mk_ir(3'b000, 5'd0), 32'h77, '0, '0, -1);
    exp_w = sbq.pop_front(); obs_w = {wb_ir, wb_type, wb_result, wb_we, wb_exc}; vec++;
    if (!done || n_req !== 0 || wb_valid !== 1'b1 || obs_w !== exp_w) begin
      err++; $display("FAIL rst_after: got v=%b req=%0d %h, exp %h", wb_valid, n_req, obs_w, exp_w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lw_fast();
    test_lb_wait();
    test_stores();
    test_load_ext();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_rst_wait();
    vec++;
    if (sbq.size() != 0) begin
      err++; $display("FAIL scoreboard_drain: got %0d left, exp 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
`default_nettype wire
